alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 184 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU. Logic, arithmetic, shift and predicate ops finish in one cycle.
// MULU (shift-add) and DIVU (restoring divide) take WIDTH RUN cycles.
module alu_multicycle #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       condition,
  input  logic [4:0]       flg_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic [4:0]       flg_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, hi_reg, lo_reg;
  logic             div_reg, p_reg, v_reg;

  // Single-cycle result, computed straight from the inputs.
  logic [WIDTH-1:0] sq;
  logic [WIDTH:0]   arith;
  logic             sp, sv, sk, ss, sz, cond_val, c, set_zs, set_v;

  always_comb begin
    sq       = B;
    sp       = flg_in[4];
    sv       = flg_in[3];
    sk       = flg_in[2];
    ss       = flg_in[1];
    sz       = flg_in[0];
    arith    = '0;
    cond_val = 1'b1;
    c        = 1'b0;
    set_zs   = 1'b0;
    set_v    = 1'b0;
    if (operation[5:4] == 2'b01) begin
      case (condition)
        4'h0:    cond_val = flg_in[0];
        4'h1:    cond_val = flg_in[1];
        4'h2:    cond_val = flg_in[2];
        4'h3:    cond_val = flg_in[3];
        4'h8:    cond_val = ~flg_in[0] & ~flg_in[2];
        4'h9:    cond_val = flg_in[1] ^ flg_in[3];
        4'hA:    cond_val = ~flg_in[0] & ~(flg_in[1] ^ flg_in[3]);
        default: cond_val = 1'b1;
      endcase
      c = (operation[3] ? (B == '0) : cond_val) ^ operation[2];
      case (operation[1:0])
        2'b00:   sp = c;
        2'b01:   sp = flg_in[4] ^ c;
        2'b10:   sp = flg_in[4] & c;
        default: sp = flg_in[4] | c;
      endcase
    end else if (operation[5:4] == 2'b00) begin
      set_zs = (operation[3:0] != 4'h0);
      set_v  = (operation[3:0] >= 4'h4);
      case (operation[3:0])
        4'h1: sq = A & B;
        4'h2: sq = A | B;
        4'h3: sq = A ^ B;
        4'h4: begin arith = {1'b0, A} + {1'b0, B}; sq = arith[WIDTH-1:0]; sk = arith[WIDTH]; end
        4'h5: begin arith = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, flg_in[2]}; sq = arith[WIDTH-1:0]; sk = arith[WIDTH]; end
        4'h6: begin arith = {1'b0, A} - {1'b0, B}; sq = arith[WIDTH-1:0]; sk = arith[WIDTH]; end
        4'h7: begin arith = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, flg_in[2]}; sq = arith[WIDTH-1:0]; sk = arith[WIDTH]; end
        4'h8: sq = {A[WIDTH-2:0], A[WIDTH-1]};
        4'h9: sq = {A[0], A[WIDTH-1:1]};
        4'hA: begin sq = {A[WIDTH-2:0], flg_in[2]}; sk = A[WIDTH-1]; end
        4'hB: begin sq = {flg_in[2], A[WIDTH-1:1]}; sk = A[0]; end
        4'hC: begin sq = {A[WIDTH-2:0], 1'b0}; sk = A[WIDTH-1]; end
        4'hD: begin sq = {1'b0, A[WIDTH-1:1]}; sk = A[0]; end
        4'hE: sq = {A[WIDTH/2-1:0], A[WIDTH-1:WIDTH/2]};
        4'hF: begin sq = {A[WIDTH-1], A[WIDTH-1:1]}; sk = A[0]; end
        default: sq = B;
      endcase
    end
    if (set_zs) begin
      sz = (sq == '0);
      ss = sq[WIDTH-1];
    end
    if (set_v)
      sv = (A[WIDTH-1] & B[WIDTH-1] & ~sq[WIDTH-1]) | (~A[WIDTH-1] & ~B[WIDTH-1] & sq[WIDTH-1]);
  end

  // One iteration step; hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_sh, div_hi, div_lo, step_hi, step_lo;
  logic [WIDTH-1:0] fin_q, fin_r;
  logic             div_ok, fin_k, fin_v;

  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    div_sh  = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
    div_ok  = {hi_reg, lo_reg[WIDTH-1]} >= {1'b0, b_reg};
    div_hi  = div_ok ? (div_sh - b_reg) : div_sh;
    div_lo  = {lo_reg[WIDTH-2:0], div_ok};
    step_hi = div_reg ? div_hi : mul_hi;
    step_lo = div_reg ? div_lo : mul_lo;
    if (div_reg) begin
      fin_q = (b_reg == '0) ? '1 : div_lo;
      fin_r = (b_reg == '0) ? a_reg : div_hi;
      fin_k = 1'b0;
      fin_v = (b_reg == '0);
    end else begin
      fin_q = mul_lo;
      fin_r = '0;
      fin_k = |mul_hi;
      fin_v = v_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      div_reg   <= 1'b0;
      p_reg     <= 1'b0;
      v_reg     <= 1'b0;
      Q         <= '0;
      R         <= '0;
      flg_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          if (start) begin
            if (operation == 6'h20 || operation == 6'h21) begin
              state_reg <= RUN;
              busy      <= 1'b1;
              cnt_reg   <= '0;
              a_reg     <= A;
              b_reg     <= B;
              div_reg   <= operation[0];
              p_reg     <= flg_in[4];
              v_reg     <= flg_in[3];
              hi_reg    <= '0;
              lo_reg    <= operation[0] ? A : B;
            end else begin
              state_reg <= DONE;
              Q         <= sq;
              R         <= '0;
              flg_out   <= {sp, sv, sk, ss, sz};
              done      <= 1'b1;
            end
          end
        end
        RUN: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            Q         <= fin_q;
            R         <= fin_r;
            flg_out   <= {p_reg, fin_v, fin_k, fin_q[WIDTH-1], fin_q == '0};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results, a negedge
// monitor pops and checks value, done timing and busy length on every done pulse.
module tb_alu_multicycle;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   operation = '0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   condition = '0;
  logic [4:0]   flg_in = '0;
  logic [W-1:0] Q, R;
  logic [4:0]   flg_out;
  logic         busy, done;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation), .A(A), .B(B),
    .condition(condition), .flg_in(flg_in), .Q(Q), .R(R), .flg_out(flg_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [4:0]   f;
    int           cyc;
    int           busy_n;
    logic [5:0]   op;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference: plain integer arithmetic on the op definitions.
  function automatic exp_t model(int op, int a, int b, int cond, int fl);
    exp_t e;
    int m = 1 << W;
    int h = m / 2;
    int p = (fl >> 4) & 1, v = (fl >> 3) & 1, k = (fl >> 2) & 1, s = (fl >> 1) & 1, z = fl & 1;
    int q = b, r = 0, c, t;
    bit zs = 0;
    longint prod;
    if (op == 32) begin
      prod = longint'(a) * longint'(b);
      q = int'(prod % m);
      k = (prod / m) != 0 ? 1 : 0;
      zs = 1;
    end else if (op == 33) begin
      if (b == 0) begin q = m - 1; r = a; v = 1; end
      else begin q = a / b; r = a % b; v = 0; end
      k = 0;
      zs = 1;
    end else if (op >= 16 && op <= 31) begin
      case (cond)
        0: c = z;
        1: c = s;
        2: c = k;
        3: c = v;
        8: c = (z == 0 && k == 0) ? 1 : 0;
        9: c = (s != v) ? 1 : 0;
        10: c = (z == 0 && s == v) ? 1 : 0;
        default: c = 1;
      endcase
      if ((op & 8) != 0) c = (b == 0) ? 1 : 0;
      c = c ^ ((op >> 2) & 1);
      case (op & 3)
        0: p = c;
        1: p = p ^ c;
        2: p = p & c;
        default: p = p | c;
      endcase
    end else if (op >= 1 && op <= 15) begin
      zs = 1;
      case (op)
        1: q = a & b;
        2: q = a | b;
        3: q = a ^ b;
        4: begin t = a + b; q = t % m; k = (t >= m) ? 1 : 0; end
        5: begin t = a + b + k; q = t % m; k = (t >= m) ? 1 : 0; end
        6: begin k = (a < b) ? 1 : 0; q = (a - b + m) % m; end
        7: begin t = b + k; k = (a < t) ? 1 : 0; q = (a - t + 2 * m) % m; end
        8: q = (a * 2) % m + a / h;
        9: q = a / 2 + (a % 2) * h;
        10: begin q = (a * 2) % m + k; k = (a >= h) ? 1 : 0; end
        11: begin q = a / 2 + k * h; k = a % 2; end
        12: begin q = (a * 2) % m; k = (a >= h) ? 1 : 0; end
        13: begin q = a / 2; k = a % 2; end
        14: q = (a % (1 << (W / 2))) * (1 << (W / 2)) + a / (1 << (W / 2));
        default: begin q = a / 2 + ((a >= h) ? h : 0); k = a % 2; end
      endcase
      if (op >= 4)
        v = (((a >= h) && (b >= h) && (q < h)) || ((a < h) && (b < h) && (q >= h))) ? 1 : 0;
    end
    if (zs) begin
      z = (q == 0) ? 1 : 0;
      s = (q >= h) ? 1 : 0;
    end
    e.q = q[W-1:0];
    e.r = r[W-1:0];
    e.f = 5'(p * 16 + v * 8 + k * 4 + s * 2 + z);
    e.cyc = 0;
    e.busy_n = 0;
    e.op = op[5:0];
    return e;
  endfunction

  // Called just after a negedge; holds start for one edge and returns at the next negedge.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] cond, input logic [4:0] fl);
    exp_t e;
    bit   multi;
    multi = (op == 6'h20) || (op == 6'h21);
    e = model(int'(op), int'(a), int'(b), int'(cond), int'(fl));
    e.cyc = cyc + 1 + (multi ? W : 0);
    e.busy_n = multi ? W : 0;
    sb.push_back(e);
    operation = op; A = a; B = b; condition = cond; flg_in = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: done still %b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: cycle %0d Q=%h R=%h flg=%b, required no done", cyc, Q, R, flg_out);
        end else begin
          e = sb.pop_front();
          if (Q !== e.q || R !== e.r || flg_out !== e.f || cyc != e.cyc || busy_run != e.busy_n) begin
            n_bad++;
            $display("FAIL op%02h: got Q=%h R=%h flg=%b cyc=%0d busy=%0d, required Q=%h R=%h flg=%b cyc=%0d busy=%0d",
                     e.op, Q, R, flg_out, cyc, busy_run, e.q, e.r, e.f, e.cyc, e.busy_n);
          end else begin
            $display("ok op%02h Q=%h R=%h flg=%b cyc=%0d", e.op, Q, R, flg_out, cyc);
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    n_cmp++;
    if (Q !== '0 || R !== '0 || flg_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got Q=%h R=%h flg=%b busy=%b done=%b, required all zero",
               tag, Q, R, flg_out, busy, done);
    end else begin
      $display("ok %s outputs zero", tag);
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [W-1:0] b;
    int r;
    #1;
    check_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(6'h04, 12'hFFF, 12'h001, 4'h0, 5'b00000);
    wait_done("add_wrap");
    @(negedge clk);
    issue(6'h20, 12'h040, 12'h040, 4'h0, 5'b01000);
    wait_done("mulu");
    @(negedge clk);
    issue(6'h21, 12'h064, 12'h007, 4'h0, 5'b01000);
    wait_done("divu");
    @(negedge clk);
    issue(6'h21, 12'h123, 12'h000, 4'h0, 5'b00000);
    wait_done("divu_zero");
    @(negedge clk);
    issue(6'h12, 12'h5A5, 12'h3C3, 4'h0, 5'b10000);
    wait_done("pred_and");
    @(negedge clk);
    issue(6'h13, 12'h5A5, 12'h3C3, 4'h0, 5'b10000);
    wait_done("pred_or");
    @(negedge clk);

    // Back-to-back: XOR issued in the ADD's DONE cycle.
    issue(6'h04, 12'h123, 12'h456, 4'h0, 5'b00000);
    issue(6'h03, 12'hF0F, 12'h0FF, 4'h0, 5'b00100);
    wait_done("b2b");
    @(negedge clk);

    // Start pulse during RUN must be ignored.
    issue(6'h20, 12'h0AB, 12'h0CD, 4'h0, 5'b00000);
    repeat (2) @(negedge clk);
    operation = 6'h04; A = 12'h001; B = 12'h001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mulu_ignore");
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-RUN aborts with no done.
    issue(6'h20, 12'h777, 12'h555, 4'h0, 5'b11111);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    check_zero("after_abort");

    // Randomized traffic, occasionally back-to-back.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) op = (r == 0) ? 6'h20 : 6'h21;
      else op = 6'($urandom_range(0, 63));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(op, W'($urandom), b, 4'($urandom), 5'($urandom));
      wait_done("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
